// File: rtl/fcml_pkg.sv
// Shared types and helpers for the FCML phase-leg carrier scheduler.
// All counts are in clk cycles; mod_add wraps a sum back into [0, p).
package fcml_pkg;

  localparam int CW_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STOP  = 2'd2,
    FAULT = 2'd3
  } state_e;

  // Operands are already below p, so one conditional subtract is enough.
  function automatic logic [CW_DEF-1:0] mod_add(input logic [CW_DEF-1:0] a,
                                                input logic [CW_DEF-1:0] b,
                                                input logic [CW_DEF-1:0] p);
    logic [CW_DEF:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, p}) begin
      sum = sum - {1'b0, p};
    end
    return sum[CW_DEF-1:0];
  endfunction

endpackage

// File: rtl/fcml_cell_cmp.sv
// One switching cell: shifts the master count by this cell's phase offset,
// compares against duty and registers the raw PWM command.
module fcml_cell_cmp
  import fcml_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmp_en,
  input  logic [CW-1:0] master,
  input  logic [CW-1:0] off,
  input  logic [CW-1:0] period,
  input  logic [CW-1:0] duty,
  output logic          dpwm
);

  logic [CW-1:0] cnt_s;
  logic          hit_s;
  logic          dpwm_r;

  // Cell count and compare; forced low whenever the leg is not switching.
  always_comb begin
    cnt_s = mod_add(master, off, period);
    hit_s = cmp_en && (cnt_s < duty);
  end

  // Output register, one cycle behind the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dpwm_r <= 1'b0;
    end else begin
      dpwm_r <= hit_s;
    end
  end

  assign dpwm = dpwm_r;

endmodule

// File: rtl/fcml_pwm_ctrl.sv
// Phase-shifted carrier scheduler for one FCML leg: run/stop/fault sequencing,
// master carrier, shadow configuration with offset sequencer, N_CELL compare cells.
module fcml_pwm_ctrl
  import fcml_pkg::*;
#(
  parameter int N_CELL = 4,
  parameter int CW     = CW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fault,
  input  logic              fault_clr,
  input  logic              cfg_ld,
  input  logic [CW-1:0]     cfg_period,
  input  logic [CW-1:0]     cfg_duty,
  input  logic [CW-1:0]     cfg_step,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic              busy,
  output logic              running,
  output logic              fault_st,
  output logic [N_CELL-1:0] dpwm
);

  localparam int            SW  = $clog2(N_CELL + 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_e        state_r, state_s;
  logic [CW-1:0] master_r;
  logic [CW-1:0] period_act_r, duty_act_r;
  logic [CW-1:0] per_pend_r, duty_pend_r, step_pend_r;
  logic [CW-1:0] off_act_r  [N_CELL];
  logic [CW-1:0] off_pend_r [N_CELL];
  logic [SW-1:0] seq_r;
  logic          busy_r, pend_rdy_r, cfg_valid_r;
  logic          cfg_ack_r, cfg_err_r, running_r, fault_st_r;
  logic          live_s, wrap_s, bad_s, accept_s, seq_done_s, apply_s, cmp_en_s;

  // Carrier boundary, config screening and the apply decision.
  always_comb begin
    live_s     = (state_r == RUN) || (state_r == STOP);
    wrap_s     = live_s && (master_r == period_act_r - ONE);
    bad_s      = (cfg_period < CW'(2)) || (cfg_step >= cfg_period);
    accept_s   = cfg_ld && !busy_r && !bad_s;
    seq_done_s = busy_r && (seq_r == SW'(N_CELL));
    // A running carrier only swaps config at a wrap so no period is split.
    apply_s    = (seq_done_s && !live_s) || (pend_rdy_r && (!live_s || wrap_s));
  end

  // Next-state logic; fault overrides everything.
  always_comb begin
    state_s = state_r;
    if (fault) begin
      state_s = FAULT;
    end else begin
      case (state_r)
        IDLE:    if (en && cfg_valid_r) state_s = RUN;  else state_s = IDLE;
        RUN:     if (!en)               state_s = STOP; else state_s = RUN;
        STOP:    if (en)                state_s = RUN;
                 else if (wrap_s)       state_s = IDLE;
                 else                   state_s = STOP;
        FAULT:   if (fault_clr && !en)  state_s = IDLE; else state_s = FAULT;
        default:                        state_s = IDLE;
      endcase
    end
    cmp_en_s = live_s && ((state_s == RUN) || (state_s == STOP));
  end

  // State register, master carrier and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      master_r   <= {CW{1'b0}};
      running_r  <= 1'b0;
      fault_st_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      running_r  <= (state_s == RUN) || (state_s == STOP);
      fault_st_r <= (state_s == FAULT);
      if (cmp_en_s && !wrap_s) begin
        master_r <= master_r + ONE;
      end else begin
        master_r <= {CW{1'b0}};
      end
    end
  end

  // Shadow capture, serial offset computation and transfer to the active set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_pend_r   <= {CW{1'b0}};
      duty_pend_r  <= {CW{1'b0}};
      step_pend_r  <= {CW{1'b0}};
      period_act_r <= {CW{1'b0}};
      duty_act_r   <= {CW{1'b0}};
      seq_r        <= {SW{1'b0}};
      busy_r       <= 1'b0;
      pend_rdy_r   <= 1'b0;
      cfg_valid_r  <= 1'b0;
      cfg_ack_r    <= 1'b0;
      cfg_err_r    <= 1'b0;
      for (int k = 0; k < N_CELL; k++) begin
        off_pend_r[k] <= {CW{1'b0}};
        off_act_r[k]  <= {CW{1'b0}};
      end
    end else begin
      cfg_ack_r <= apply_s;
      cfg_err_r <= cfg_ld && !busy_r && bad_s;
      if (accept_s) begin
        per_pend_r    <= cfg_period;
        duty_pend_r   <= cfg_duty;
        step_pend_r   <= cfg_step;
        off_pend_r[0] <= {CW{1'b0}};
        seq_r         <= SW'(1);
        busy_r        <= 1'b1;
        pend_rdy_r    <= 1'b0;
      end else if (busy_r) begin
        for (int k = 1; k < N_CELL; k++) begin
          if (seq_r == SW'(k)) begin
            off_pend_r[k] <= mod_add(off_pend_r[k-1], step_pend_r, per_pend_r);
          end
        end
        if (seq_done_s) begin
          busy_r     <= 1'b0;
          seq_r      <= {SW{1'b0}};
          pend_rdy_r <= live_s;
        end else begin
          seq_r <= seq_r + SW'(1);
        end
      end else if (apply_s) begin
        pend_rdy_r <= 1'b0;
      end
      if (apply_s) begin
        period_act_r <= per_pend_r;
        duty_act_r   <= duty_pend_r;
        cfg_valid_r  <= 1'b1;
        for (int k = 0; k < N_CELL; k++) begin
          off_act_r[k] <= off_pend_r[k];
        end
      end
    end
  end

  for (genvar k = 0; k < N_CELL; k++) begin : g_cell
    fcml_cell_cmp #(.CW(CW)) u_cmp (
      .clk    (clk),
      .rst    (rst),
      .cmp_en (cmp_en_s),
      .master (master_r),
      .off    (off_act_r[k]),
      .period (period_act_r),
      .duty   (duty_act_r),
      .dpwm   (dpwm[k])
    );
  end

  assign cfg_ack  = cfg_ack_r;
  assign cfg_err  = cfg_err_r;
  assign busy     = busy_r;
  assign running  = running_r;
  assign fault_st = fault_st_r;

endmodule

// File: tb/tb_fcml_pwm_ctrl.sv
// Directed bench for fcml_pwm_ctrl: config handshake, phase-shifted outputs,
// shadow update at the carrier wrap, stop/fault sequencing and reset.
module tb_fcml_pwm_ctrl;

  localparam int N  = 4;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, fault = 1'b0, fault_clr = 1'b0, cfg_ld = 1'b0;
  logic [CW-1:0] cfg_period = 10'd0, cfg_duty = 10'd0, cfg_step = 10'd0;
  logic          cfg_ack, cfg_err, busy, running, fault_st;
  logic [N-1:0]  dpwm;

  int n_pass = 0;
  int n_chk  = 0;
  int mst, cur_per, cur_duty, cur_step;
  int acks;
  int ones [N];

  // period 8, duty 4, offsets {0,2,4,6}: dpwm indexed by the master value it reflects
  logic [3:0] tab [8] = '{4'b0011, 4'b0011, 4'b1001, 4'b1001,
                          4'b1100, 4'b1100, 4'b0110, 4'b0110};

  fcml_pwm_ctrl #(.N_CELL(N), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fault      (fault),
    .fault_clr  (fault_clr),
    .cfg_ld     (cfg_ld),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .cfg_step   (cfg_step),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .running    (running),
    .fault_st   (fault_st),
    .dpwm       (dpwm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [N-1:0] exp_pwm(input int m);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) begin
      r[k] = (((m + (k * cur_step) % cur_per) % cur_per) < cur_duty);
    end
    return r;
  endfunction

  // One running cycle: dpwm must reflect the master value of the previous cycle.
  task automatic tick_chk(input string tag);
    int m;
    m = mst;
    cycles(1);
    check(tag, 32'(dpwm), 32'(exp_pwm(m)));
    mst = (m == cur_per - 1) ? 0 : m + 1;
  endtask

  task automatic load_idle(input int p, input int d, input int s);
    cfg_period = CW'(p);
    cfg_duty   = CW'(d);
    cfg_step   = CW'(s);
    cfg_ld     = 1'b1;
    cycles(1);
    cfg_ld = 1'b0;
    cycles(4);
    check("ack_idle", 32'(cfg_ack), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    cycles(3);
    check("rst_out", 32'({cfg_ack, cfg_err, busy, running, fault_st, dpwm}), 32'd0);
    rst = 1'b1;
    en  = 1'b1;
    cycles(3);
    check("no_cfg_run", 32'(running), 32'd0);
    en = 1'b0;

    // config in IDLE: busy four cycles, ack on the fifth
    cfg_period = 10'd8; cfg_duty = 10'd4; cfg_step = 10'd2; cfg_ld = 1'b1;
    cycles(1);
    cfg_ld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("busy_idle", 32'(busy), 32'd1);
      check("ack_early", 32'(cfg_ack), 32'd0);
      cycles(1);
    end
    check("busy_fall", 32'(busy), 32'd0);
    check("ack_t5", 32'(cfg_ack), 32'd1);
    check("err_none", 32'(cfg_err), 32'd0);
    cycles(1);
    check("ack_once", 32'(cfg_ack), 32'd0);

    // start: first cycle master=0, outputs still low
    cur_per = 8; cur_duty = 4; cur_step = 2;
    en = 1'b1;
    cycles(1);
    check("run_first_st", 32'(running), 32'd1);
    check("run_first_pwm", 32'(dpwm), 32'd0);
    mst = 0;
    for (int i = 0; i < 16; i++) begin
      int m;
      m = mst;
      tick_chk("pwm_842");
      check("pwm_tab", 32'(dpwm), 32'(tab[m]));
    end

    // duty change mid-period takes effect at the next master=0
    while (mst != 2) tick_chk("pwm_842");
    cfg_duty = 10'd6; cfg_ld = 1'b1;
    tick_chk("pwm_old");
    cfg_ld = 1'b0;
    check("busy_run", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) tick_chk("pwm_old");
    check("busy_run_fall", 32'(busy), 32'd0);
    check("ack_before_wrap", 32'(cfg_ack), 32'd0);
    tick_chk("pwm_old_last");
    check("ack_wrap", 32'(cfg_ack), 32'd1);
    cur_duty = 6;
    for (int k = 0; k < N; k++) ones[k] = 0;
    for (int i = 0; i < 8; i++) begin
      tick_chk("pwm_d6");
      if (i == 0) check("ack_single", 32'(cfg_ack), 32'd0);
      for (int k = 0; k < N; k++) ones[k] += int'(dpwm[k]);
    end
    for (int k = 0; k < N; k++) check("high6", 32'(ones[k]), 32'd6);

    // rejected configs
    cfg_period = 10'd1; cfg_step = 10'd0; cfg_ld = 1'b1;
    tick_chk("pwm_d6");
    cfg_ld = 1'b0;
    check("err_p1", 32'(cfg_err), 32'd1);
    check("err_p1_busy", 32'(busy), 32'd0);
    acks = 0;
    for (int i = 0; i < 9; i++) begin
      tick_chk("pwm_d6");
      acks += int'(cfg_ack);
    end
    check("err_p1_noack", 32'(acks), 32'd0);
    cfg_period = 10'd8; cfg_step = 10'd8; cfg_ld = 1'b1;
    tick_chk("pwm_d6");
    cfg_ld = 1'b0;
    check("err_step", 32'(cfg_err), 32'd1);
    tick_chk("pwm_d6");
    check("err_pulse", 32'(cfg_err), 32'd0);

    // cfg_ld while busy is dropped silently
    cfg_step = 10'd2; cfg_ld = 1'b1;
    tick_chk("pwm_d6");
    cfg_period = 10'd1;
    tick_chk("pwm_d6");
    cfg_ld = 1'b0;
    check("busy_ign_err", 32'(cfg_err), 32'd0);
    tick_chk("pwm_d6");
    tick_chk("pwm_d6");
    check("busy_ign_t4", 32'(busy), 32'd1);
    tick_chk("pwm_d6");
    check("busy_ign_t5", 32'(busy), 32'd0);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick_chk("pwm_d6");
      acks += int'(cfg_ack);
    end
    check("busy_ign_ack", 32'(acks), 32'd1);

    // en drops at master=3: finish the carrier, then IDLE
    while (mst != 3) tick_chk("pwm_d6");
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_chk("pwm_stop");
      check("stop_running", 32'(running), 32'd1);
    end
    cycles(1);
    check("stop_idle_pwm", 32'(dpwm), 32'd0);
    check("stop_idle_st", 32'(running), 32'd0);
    cycles(2);
    check("idle_pwm", 32'(dpwm), 32'd0);

    // duty 0: constant low
    load_idle(8, 0, 2);
    cur_duty = 0;
    en = 1'b1;
    cycles(1);
    mst = 0;
    for (int i = 0; i < 8; i++) begin
      tick_chk("pwm_d0");
      check("duty0", 32'(dpwm), 32'd0);
    end
    en = 1'b0;
    cycles(10);
    check("d0_idle", 32'(running), 32'd0);

    // duty = period: constant high, then fault at master=2
    load_idle(8, 8, 2);
    cur_duty = 8;
    en = 1'b1;
    cycles(1);
    mst = 0;
    for (int i = 0; i < 8; i++) begin
      tick_chk("pwm_d8");
      check("duty8", 32'(dpwm), 32'hF);
    end
    while (mst != 2) tick_chk("pwm_d8");
    fault = 1'b1;
    cycles(1);
    check("fault_pwm", 32'(dpwm), 32'd0);
    check("fault_st", 32'(fault_st), 32'd1);
    check("fault_run", 32'(running), 32'd0);
    fault_clr = 1'b1;
    cycles(1);
    check("clr_fault_hi", 32'(fault_st), 32'd1);
    fault = 1'b0;
    cycles(1);
    fault_clr = 1'b0;
    check("clr_en_hi", 32'(fault_st), 32'd1);
    check("fault_hold_pwm", 32'(dpwm), 32'd0);
    en = 1'b0;
    fault_clr = 1'b1;
    cycles(1);
    fault_clr = 1'b0;
    check("clr_ok", 32'(fault_st), 32'd0);
    check("clr_idle", 32'(running), 32'd0);

    // asynchronous reset mid-RUN clears cfg_valid
    load_idle(8, 4, 2);
    cur_duty = 4;
    en = 1'b1;
    cycles(1);
    mst = 0;
    for (int i = 0; i < 5; i++) tick_chk("pwm_pre_rst");
    rst = 1'b0;
    #1;
    check("rst_mid_pwm", 32'(dpwm), 32'd0);
    check("rst_mid_run", 32'(running), 32'd0);
    cycles(1);
    rst = 1'b1;
    cycles(4);
    check("no_restart", 32'(running), 32'd0);
    check("no_restart_pwm", 32'(dpwm), 32'd0);
    en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
